// File: rtl/video_timing_gen.sv
// Programmable video timing generator: signed h/v counters, sync/blank decode,
// and double-buffered timing registers that swap in only at frame end.
module video_timing_gen #(
  parameter int unsigned W          = 12,
  parameter int unsigned H_RES_D    = 640,
  parameter int unsigned H_FP_D     = 16,
  parameter int unsigned H_SP_D     = 96,
  parameter int unsigned H_BP_D     = 48,
  parameter int unsigned V_RES_D    = 480,
  parameter int unsigned V_FP_D     = 10,
  parameter int unsigned V_SP_D     = 2,
  parameter int unsigned V_BP_D     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [W-1:0]        cfg_wdata,
  output logic                cfg_pending,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                de,
  output logic signed [W+1:0] hpos,
  output logic signed [W+1:0] vpos,
  output logic                line_end,
  output logic                frame_end
);

  typedef logic signed [W+1:0] pos_t;

  localparam pos_t HPOS_RST = pos_t'(-(int'(H_FP_D + H_SP_D + H_BP_D)));
  localparam pos_t VPOS_RST = pos_t'(-(int'(V_FP_D + V_SP_D + V_BP_D)));

  logic [W-1:0] r_shadow [8];
  logic [W-1:0] r_active [8];
  logic         r_pending;
  pos_t         r_hpos;
  pos_t         r_vpos;

  logic         w_wr_ok;
  logic         w_h_last;
  logic         w_v_last;
  logic         w_hs_in;
  logic         w_vs_in;
  pos_t         w_h_porch;
  pos_t         w_v_porch;
  pos_t         w_h_porch_nxt;
  pos_t         w_v_porch_nxt;

  function automatic pos_t ext(input logic [W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic [W-1:0] dflt(input int unsigned i);
    case (i)
      0:       return W'(H_RES_D);
      1:       return W'(H_FP_D);
      2:       return W'(H_SP_D);
      3:       return W'(H_BP_D);
      4:       return W'(V_RES_D);
      5:       return W'(V_FP_D);
      6:       return W'(V_SP_D);
      default: return W'(V_BP_D);
    endcase
  endfunction

  always_comb begin
    w_h_porch     = ext(r_active[1]) + ext(r_active[2]) + ext(r_active[3]);
    w_v_porch     = ext(r_active[5]) + ext(r_active[6]) + ext(r_active[7]);
    w_h_porch_nxt = ext(r_shadow[1]) + ext(r_shadow[2]) + ext(r_shadow[3]);
    w_v_porch_nxt = ext(r_shadow[5]) + ext(r_shadow[6]) + ext(r_shadow[7]);
    w_h_last      = (r_hpos == ext(r_active[0]) - pos_t'(1));
    w_v_last      = (r_vpos == ext(r_active[4]) - pos_t'(1));
    w_hs_in       = (r_hpos >= -(ext(r_active[2]) + ext(r_active[3]))) &&
                    (r_hpos < -ext(r_active[3]));
    w_vs_in       = (r_vpos >= -(ext(r_active[6]) + ext(r_active[7]))) &&
                    (r_vpos < -ext(r_active[7]));
    w_wr_ok       = cfg_we && !((cfg_wdata == '0) &&
                                ((cfg_addr == 3'd0) || (cfg_addr == 3'd4)));
    line_end      = enable && w_h_last;
    frame_end     = line_end && w_v_last;
    hsync         = w_hs_in ? H_SYNC_POL : ~H_SYNC_POL;
    vsync         = w_vs_in ? V_SYNC_POL : ~V_SYNC_POL;
    blank         = (r_hpos < 0) || (r_vpos < 0);
    de            = ~blank;
    hpos          = r_hpos;
    vpos          = r_vpos;
    cfg_pending   = r_pending;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_shadow[i] <= dflt(i);
        r_active[i] <= dflt(i);
      end
      r_pending <= 1'b0;
      r_hpos    <= HPOS_RST;
      r_vpos    <= VPOS_RST;
    end else begin
      if (enable) begin
        // At frame end the wrap targets come from the shadow set being loaded,
        // so the new mode governs the very first count of the next frame.
        if (w_h_last) begin
          r_hpos <= frame_end ? -w_h_porch_nxt : -w_h_porch;
          if (w_v_last) r_vpos <= -w_v_porch_nxt;
          else          r_vpos <= r_vpos + pos_t'(1);
        end else begin
          r_hpos <= r_hpos + pos_t'(1);
        end
      end
      if (frame_end) begin
        for (int unsigned i = 0; i < 8; i++) r_active[i] <= r_shadow[i];
        r_pending <= 1'b0;
      end
      // A write landing on the load cycle stays in shadow for the next frame.
      if (w_wr_ok) begin
        r_shadow[cfg_addr] <= cfg_wdata;
        r_pending          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: pixel/line index model plus directed and random
// sequences, including a write table and mid-line reset.
module tb_video_timing_gen;
  localparam int W  = 12;
  localparam int HR = 640, HF = 16, HS = 96, HB = 48;
  localparam int VR = 4,   VF = 1,  VS = 1,  VB = 1;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [W-1:0] cfg_wdata = '0;
  logic cfg_pending, hsync, vsync, blank, de, line_end, frame_end;
  logic signed [W+1:0] hpos, vpos;

  video_timing_gen #(
    .W(W), .H_RES_D(HR), .H_FP_D(HF), .H_SP_D(HS), .H_BP_D(HB),
    .V_RES_D(VR), .V_FP_D(VF), .V_SP_D(VS), .V_BP_D(VB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_pending(cfg_pending),
    .hsync(hsync), .vsync(vsync), .blank(blank), .de(de), .hpos(hpos),
    .vpos(vpos), .line_end(line_end), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int DEF [8] = '{HR, HF, HS, HB, VR, VF, VS, VB};
  int act [8], shd [8];
  int mh, mv;
  bit pend, m_le, m_fe;
  bit prev_de = 1'b0, prev_hs = 1'b1, last_fe_dut;
  int hs_act_cnt, hmin, hmax;
  int le_q[$], fe_q[$], de_fall_q[$], hs_start_q[$], hs_end_q[$];

  typedef struct { bit we; bit [2:0] a; bit [W-1:0] d; bit exp_pend; } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (act[i]) begin act[i] = DEF[i]; shd[i] = DEF[i]; end
    mh = 0; mv = 0; pend = 1'b0;
  endtask

  function automatic int hpm(); return mh - (act[1] + act[2] + act[3]); endfunction
  function automatic int vpm(); return mv - (act[5] + act[6] + act[7]); endfunction
  function automatic bit pred_fe();
    return (hpm() == act[0] - 1) && (vpm() == act[4] - 1);
  endfunction

  task automatic compare(input bit en);
    int hp = hpm();
    int vp = vpm();
    bit hs_in = (hp >= -(act[2] + act[3])) && (hp < -act[3]);
    bit vs_in = (vp >= -(act[6] + act[7])) && (vp < -act[7]);
    m_le = en && (hp == act[0] - 1);
    m_fe = m_le && (vp == act[4] - 1);
    chk("hpos", int'(hpos), hp);
    chk("vpos", int'(vpos), vp);
    chk("hsync", int'(hsync), int'(hs_in ? HPOL : !HPOL));
    chk("vsync", int'(vsync), int'(vs_in ? VPOL : !VPOL));
    chk("blank", int'(blank), int'(hp < 0 || vp < 0));
    chk("de", int'(de), int'(!(hp < 0 || vp < 0)));
    chk("line_end", int'(line_end), int'(m_le));
    chk("frame_end", int'(frame_end), int'(m_fe));
    chk("cfg_pending", int'(cfg_pending), int'(pend));
    if (line_end) le_q.push_back(cyc);
    if (frame_end) fe_q.push_back(cyc);
    if (prev_de && !de) de_fall_q.push_back(cyc);
    if (prev_hs != HPOL && hsync == HPOL) hs_start_q.push_back(cyc);
    if (prev_hs == HPOL && hsync != HPOL) hs_end_q.push_back(cyc);
    if (hsync == HPOL) hs_act_cnt++;
    if (int'(hpos) < hmin) hmin = int'(hpos);
    if (int'(hpos) > hmax) hmax = int'(hpos);
    prev_de = de; prev_hs = hsync; last_fe_dut = frame_end;
  endtask

  task automatic step(input bit en, input bit we, input bit [2:0] a, input bit [W-1:0] d);
    enable = en; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    #1;
    compare(en);
    @(posedge clk);
    if (en) begin
      if (m_le) begin mh = 0; mv = m_fe ? 0 : mv + 1; end
      else mh++;
    end
    if (m_fe) begin foreach (act[i]) act[i] = shd[i]; pend = 1'b0; end
    if (we && !(d == 0 && (a == 0 || a == 4))) begin shd[a] = int'(d); pend = 1'b1; end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, '0);
  endtask

  task automatic run_to_fe(input int lim);
    int n = 0;
    do begin step(1'b1, 1'b0, 3'd0, '0); n++; end while (!m_fe && n < lim);
    chk("fe_reached", int'(last_fe_dut), 1);
  endtask

  initial begin
    int s, e, d0;
    model_reset();
    #12;
    // reset state
    chk("rst_hpos", int'(hpos), -(HF + HS + HB));
    chk("rst_vpos", int'(vpos), -(VF + VS + VB));
    chk("rst_blank", int'(blank), 1);
    chk("rst_hsync", int'(hsync), int'(!HPOL));
    @(negedge clk);
    reset_n = 1'b1;

    // default horizontal timing, short vertical frame
    run(11300);
    chk("le_count_ge2", int'(le_q.size() >= 2), 1);
    if (le_q.size() >= 2) chk("line_period", le_q[1] - le_q[0], HR + HF + HS + HB);
    chk("fe_count", fe_q.size(), 2);
    if (fe_q.size() >= 2) chk("frame_period", fe_q[1] - fe_q[0], (HR + HF + HS + HB) * (VR + VF + VS + VB));
    d0 = (de_fall_q.size() > 0) ? de_fall_q[0] : 0;
    s = -1; e = -1;
    foreach (hs_start_q[i]) if (s < 0 && hs_start_q[i] >= d0) s = hs_start_q[i];
    foreach (hs_end_q[i]) if (e < 0 && s >= 0 && hs_end_q[i] > s) e = hs_end_q[i];
    chk("de_to_hsync", s - d0, HF);
    chk("hsync_width", e - s, HS);

    // small mode written mid-frame
    run(300);
    step(1, 1, 3'd0, 4); step(1, 1, 3'd1, 1); step(1, 1, 3'd2, 2); step(1, 1, 3'd3, 1);
    step(1, 1, 3'd4, 2); step(1, 1, 3'd5, 1); step(1, 1, 3'd6, 1); step(1, 1, 3'd7, 1);
    chk("pend_after_wr", int'(cfg_pending), 1);
    run_to_fe(6000);
    chk("pend_after_load", int'(cfg_pending), 0);
    hmin = 1000; hmax = -1000;
    run(80);
    chk("small_hmin", hmin, -4);
    chk("small_hmax", hmax, 3);

    // enable toggling doubles the frame period
    fe_q.delete();
    for (int i = 0; i < 200; i++) step(i % 2 == 0, 1'b0, 3'd0, '0);
    chk("toggle_fe_count_ge2", int'(fe_q.size() >= 2), 1);
    if (fe_q.size() >= 2) chk("toggle_frame_period", fe_q[1] - fe_q[0], 80);

    // write coinciding with frame_end
    step(1, 1, 3'd7, 2);
    for (int i = 0; i < 100 && !pred_fe(); i++) step(1, 0, 3'd0, '0);
    step(1, 1, 3'd0, 6);
    chk("coinc_fe_seen", int'(last_fe_dut), 1);
    chk("pend_across_frame", int'(cfg_pending), 1);
    hmin = 1000; hmax = -1000;
    run_to_fe(200);
    chk("old_hres_kept", hmax, 3);
    chk("pend_cleared_late", int'(cfg_pending), 0);
    hmin = 1000; hmax = -1000;
    run_to_fe(200);
    chk("new_hres_applied", hmax, 5);

    // write table: zero resolution writes are ignored
    tbl[0] = '{1'b1, 3'd0, '0, 1'b0};
    tbl[1] = '{1'b1, 3'd4, '0, 1'b0};
    tbl[2] = '{1'b0, 3'd0, '0, 1'b0};
    tbl[3] = '{1'b1, 3'd2, '0, 1'b1};
    tbl[4] = '{1'b1, 3'd0, '0, 1'b1};
    tbl[5] = '{1'b1, 3'd1, '0, 1'b1};
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl_pend_%0d", i), int'(cfg_pending), int'(tbl[i].exp_pend));
    end
    run_to_fe(400);
    hs_act_cnt = 0;
    run_to_fe(400);
    chk("hsync_never_sp0", hs_act_cnt, 0);

    // randomized modes, enables and writes
    for (int i = 0; i < 3000; i++) begin
      bit [2:0] a = 3'($urandom_range(0, 7));
      int unsigned dv = (a == 0 || a == 4) ? $urandom_range(0, 6) : $urandom_range(0, 3);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a, W'(dv));
    end

    // reset mid-line with a pending write
    step(1, 1, 3'd1, 3);
    run(3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_hpos", int'(hpos), -(HF + HS + HB));
    chk("mid_rst_vpos", int'(vpos), -(VF + VS + VB));
    chk("mid_rst_blank", int'(blank), 1);
    chk("mid_rst_de", int'(de), 0);
    chk("mid_rst_hsync", int'(hsync), int'(!HPOL));
    chk("mid_rst_vsync", int'(vsync), int'(!VPOL));
    chk("mid_rst_pend", int'(cfg_pending), 0);
    chk("mid_rst_le", int'(line_end), 0);
    chk("mid_rst_fe", int'(frame_end), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    prev_de = 1'b0; prev_hs = !HPOL;
    run(900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
